// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: word geometry, default scan parameters and controller states
package shift_ctrl_pkg;
    localparam int WORD_W  = 512;
    localparam int DEF_BPW = 256;
    localparam int DEF_OVL = 10;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/shift_ctrl_shift2_cnt.sv
// shift2_cnt: per-word base counter with load-to-value and terminal flag
module shift2_cnt
    import shift_ctrl_pkg::*;
#(
    parameter int BPW = DEF_BPW,
    parameter int CW  = $clog2(BPW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_i,
    input  logic [CW-1:0] ld_val_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          term_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d  = ld_i ? ld_val_i : inc_i ? cnt_q + CW'(1) : cnt_q;
    assign cnt_o  = cnt_q;
    assign term_o = cnt_q == CW'(BPW - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: sequences load/shift commands of a 2-bit-base shift register
// and reports each new window with its global base position.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int BPW  = DEF_BPW,
    parameter int OVL  = DEF_OVL,
    parameter int POSW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              stall,
    output logic              sr_load,
    output logic              sr_shift,
    output logic [WORD_W-1:0] sr_data,
    output logic              sr_valid,
    output logic              win_valid,
    output logic [POSW-1:0]   base_pos,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(BPW);

    state_t          state_q, state_d;
    logic            last_seen_q, first_q, win_valid_q;
    logic [POSW-1:0] base_pos_q;
    logic [CW-1:0]   cnt, ld_val;
    logic            term, take, boundary, cnt_inc;

    shift2_cnt #(.BPW(BPW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .ld_i     (sr_load),
        .ld_val_i (ld_val),
        .inc_i    (cnt_inc),
        .cnt_o    (cnt),
        .term_o   (term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!stall)
            unique case (state_q)
                S_IDLE, S_DONE: state_d = start ? S_LOAD : state_q;
                S_LOAD:         state_d = in_valid ? S_RUN : S_LOAD;
                S_RUN:          state_d = !term ? S_RUN : last_seen_q ? S_DONE : in_valid ? S_RUN : S_WAIT;
                S_WAIT:         state_d = in_valid ? S_RUN : S_WAIT;
                default:        state_d = S_IDLE;
            endcase
    end

    // boundary: combined load&shift that swaps in the next word at cnt BPW-1
    always_comb begin
        boundary = !stall && in_valid && ((state_q == S_RUN && term && !last_seen_q) || state_q == S_WAIT);
        sr_load  = (!stall && in_valid && state_q == S_LOAD) || boundary;
        sr_shift = (!stall && state_q == S_RUN && !term) || boundary;
        cnt_inc  = sr_shift && !boundary;
        ld_val   = boundary ? '0 : CW'(OVL);
        in_ready = sr_load;
        sr_valid = sr_load;
        sr_data  = in_data;
        busy     = state_q == S_LOAD || state_q == S_RUN || state_q == S_WAIT;
        done     = state_q == S_DONE;
        take     = start && !stall && (state_q == S_IDLE || state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_seen_q <= 1'b0;
            first_q     <= 1'b0;
            win_valid_q <= 1'b0;
            base_pos_q  <= '0;
        end else begin
            win_valid_q <= sr_load || sr_shift;
            if (take) begin
                last_seen_q <= 1'b0;
                first_q     <= 1'b1;
                base_pos_q  <= '0;
            end else begin
                if (in_ready) last_seen_q <= in_last;
                if (sr_load || sr_shift) begin
                    first_q    <= 1'b0;
                    base_pos_q <= first_q ? '0 : base_pos_q + POSW'(1);
                end
            end
        end
    end

    assign win_valid = win_valid_q;
    assign base_pos  = base_pos_q;
endmodule
